accel_mmio_bridge: RTL and testbench

//  Initiator side of the accelerator register file. Converts RISC-V core MMIO requests (valid/ready)

---
 rtl/accel_pkg.sv | 30 +++
 rtl/accel_mmio_bridge.sv | 137 +++++++++++++
 tb/tb_accel_mmio_bridge.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/accel_pkg.sv
// Shared constants, state type and byte-merge helper
// for the accelerator MMIO bridge.
package accel_pkg;

  localparam int NUM_REGS  = 48;
  localparam int RO_BASE   = 40;
  localparam int REG_IDX_W = 6;
  localparam int ADDR_W    = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } bridge_state_t;

  // Byte-wise select: strb bit set takes the new byte.
  function automatic logic [31:0] merge_bytes(
    input logic [31:0] old_w,
    input logic [31:0] new_w,
    input logic [3:0]  strb
  );
    logic [31:0] res;
    res = old_w;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/accel_mmio_bridge.sv
// Core MMIO request -> register_map access bridge.
// One response per request; IDLE -> EXEC -> RESP.
module accel_mmio_bridge
  import accel_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic [31:0]          req_wdata,
  input  logic [3:0]           req_wstrb,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_rdata,
  output logic                 rsp_err,
  output logic [7:0]           err_count,
  output logic [REG_IDX_W-1:0] rm_read_reg1,
  input  logic [31:0]          rm_read_data1,
  output logic [REG_IDX_W-1:0] rm_write_reg,
  output logic                 rm_reg_write,
  output logic [31:0]          rm_write_data
);

  localparam logic [REG_IDX_W-1:0] NR_I =
    REG_IDX_W'(NUM_REGS);
  localparam logic [REG_IDX_W-1:0] RO_I =
    REG_IDX_W'(RO_BASE);

  bridge_state_t        state_q, state_d;
  logic                 write_q, write_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [3:0]           wstrb_q, wstrb_d;
  logic [REG_IDX_W-1:0] idx_q, idx_d;
  logic [31:0]          rdata_q, rdata_d;
  logic                 err_q, err_d;
  logic [7:0]           cnt_q, cnt_d;

  logic [REG_IDX_W-1:0] req_idx;
  logic [REG_IDX_W-1:0] lat_idx;
  logic                 acc_err;

  assign req_idx = req_addr[ADDR_W-1:2];
  assign lat_idx = addr_q[ADDR_W-1:2];
  assign acc_err = (addr_q[1:0] != 2'b00)
                || (lat_idx >= NR_I)
                || (write_q && (lat_idx >= RO_I));

  assign req_ready    = (state_q == IDLE);
  assign rsp_valid    = (state_q == RESP);
  assign rsp_rdata    = rdata_q;
  assign rsp_err      = err_q;
  assign err_count    = cnt_q;
  assign rm_read_reg1 = idx_q;
  assign rm_write_reg = idx_q;

  // Next-state, request capture and EXEC-cycle access.
  always_comb begin
    state_d       = state_q;
    write_d       = write_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    idx_d         = idx_q;
    rdata_d       = rdata_q;
    err_d         = err_q;
    cnt_d         = cnt_q;
    rm_reg_write  = 1'b0;
    rm_write_data = 32'h0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          wstrb_d = req_wstrb;
          // Keep register_map away from
          // unimplemented indices.
          idx_d   = (req_idx >= NR_I) ? '0 : req_idx;
          state_d = EXEC;
        end
      end
      EXEC: begin
        state_d = RESP;
        if (acc_err) begin
          rdata_d = 32'h0;
          err_d   = 1'b1;
          if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
        end else begin
          err_d = 1'b0;
          if (write_q) begin
            rdata_d = 32'h0;
            if (wstrb_q != 4'h0) begin
              rm_reg_write  = 1'b1;
              rm_write_data = merge_bytes(
                rm_read_data1, wdata_q, wstrb_q);
            end
          end else begin
            rdata_d = rm_read_data1;
          end
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      wstrb_q <= 4'h0;
      idx_q   <= '0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
      cnt_q   <= 8'h0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      idx_q   <= idx_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_accel_mmio_bridge.sv
// Scoreboard bench for accel_mmio_bridge with a
// behavioural register file and random traffic.
module tb_accel_mmio_bridge;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [7:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_wstrb = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [7:0]  err_count;
  logic [5:0]  rm_read_reg1;
  logic [31:0] rm_read_data1;
  logic [5:0]  rm_write_reg;
  logic        rm_reg_write;
  logic [31:0] rm_write_data;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic [7:0]  cnt;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mem [48];
  logic [31:0] ref_mem [48];
  int          ref_cnt = 0;
  int          exp_pulses = 0;
  int          pulses = 0;
  logic [31:0] last_wd = '0;
  int          bp_mode = 2;
  int          checks = 0;
  int          failures = 0;

  accel_mmio_bridge dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .err_count(err_count),
    .rm_read_reg1(rm_read_reg1),
    .rm_read_data1(rm_read_data1),
    .rm_write_reg(rm_write_reg),
    .rm_reg_write(rm_reg_write),
    .rm_write_data(rm_write_data)
  );

  always #5 clk = ~clk;

  // Register map stand-in: comb read, clocked write.
  assign rm_read_data1 = (rm_read_reg1 < 6'd48)
    ? mem[rm_read_reg1] : 32'hBAD0BAD0;
  always @(posedge clk)
    if (rm_reg_write && rm_write_reg < 6'd48)
      mem[rm_write_reg] <= rm_write_data;

  // rsp_ready: 0 random, 1 held low, 2 held high.
  always @(posedge clk) begin
    #1;
    case (bp_mode)
      0: rsp_ready = ($urandom_range(0, 1) == 1);
      1: rsp_ready = 1'b0;
      default: rsp_ready = 1'b1;
    endcase
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  // Monitor: write pulses and response handshakes.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rm_reg_write) begin
        pulses++;
        last_wd = rm_write_data;
        chk("wr_idx_range",
            32'(rm_write_reg < 6'd48), 32'd1);
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_err", 32'(rsp_err), 32'(e.err));
          chk("err_count", 32'(err_count), 32'(e.cnt));
        end
      end
    end
  end

  // Reference: decode the byte address directly.
  function automatic exp_t model(input bit wr,
                                 input logic [7:0] a,
                                 input logic [31:0] d,
                                 input logic [3:0] s);
    exp_t e;
    int idx;
    bit bad;
    idx = int'(a) / 4;
    bad = (int'(a) % 4 != 0) || idx >= 48
       || (wr && idx >= 40);
    e.err = bad;
    e.rdata = 32'h0;
    if (bad) begin
      if (ref_cnt < 255) ref_cnt++;
    end else if (wr) begin
      for (int b = 0; b < 4; b++)
        if (s[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
      if (s != 4'h0) exp_pulses++;
    end else begin
      e.rdata = ref_mem[idx];
    end
    e.cnt = 8'(ref_cnt);
    return e;
  endfunction

  task automatic issue(input bit wr,
                       input logic [7:0] a,
                       input logic [31:0] d,
                       input logic [3:0] s,
                       input bit track);
    int n;
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = wr;
    req_addr = a; req_wdata = d; req_wstrb = s;
    n = 0;
    do begin
      @(negedge clk); n++;
    end while (!req_ready && n < 200);
    if (!req_ready) chk("accept_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_write = ($urandom_range(0, 1) == 1);
    req_addr  = 8'($urandom);
    req_wdata = $urandom;
    req_wstrb = 4'($urandom);
    if (track) exp_q.push_back(model(wr, a, d, s));
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || !req_ready)
           && n < 2000) begin
      @(negedge clk); n++;
    end
    if (n >= 2000) chk("drain_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    bit wr;
    logic [7:0] a;
    logic [31:0] hold_d;
    int n;
    for (int i = 0; i < 48; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    repeat (3) @(posedge clk);
    #2;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    chk("rst_rm_wr", 32'(rm_reg_write), 32'd0);
    rst_n = 1'b1;

    issue(1, 8'h14, 32'hDEADBEEF, 4'hF, 1);
    issue(0, 8'h14, 32'h0, 4'h0, 1);
    drain();
    chk("t1_pulses", 32'(pulses), 32'd1);

    issue(1, 8'h14, 32'h11223344, 4'b0101, 1);
    drain();
    chk("t2_merge", last_wd, 32'hDE22BE44);
    issue(0, 8'h14, 32'h0, 4'h0, 1);

    issue(0, 8'h16, 32'h0, 4'h0, 1);
    issue(0, 8'hC0, 32'h0, 4'h0, 1);
    issue(1, 8'hA0, 32'h12345678, 4'hF, 1);
    drain();
    chk("t3_err_count", 32'(err_count), 32'd3);
    chk("t3_pulses", 32'(pulses), 32'd2);

    bp_mode = 1;
    @(posedge clk); #2;
    issue(0, 8'h20, 32'h0, 4'h0, 1);
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clk); n++;
    end
    hold_d = rsp_rdata;
    chk("t4_rdata", hold_d, ref_mem[8]);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_valid_hold", 32'(rsp_valid), 32'd1);
      chk("t4_rdata_hold", rsp_rdata, hold_d);
      chk("t4_req_ready", 32'(req_ready), 32'd0);
    end
    bp_mode = 2;
    n = 0;
    while (rsp_valid && n < 20) begin
      @(negedge clk); n++;
    end
    chk("t4_back_idle", 32'(req_ready), 32'd1);
    drain();

    bp_mode = 0;
    for (int i = 0; i < 200; i++) begin
      wr = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 9) < 7)
        a = 8'($urandom_range(0, 47) * 4);
      else
        a = 8'($urandom);
      issue(wr, a, $urandom,
            ($urandom_range(0, 7) == 0) ? 4'h0
                                        : 4'($urandom),
            1);
    end
    drain();

    bp_mode = 2;
    hold_d = ref_mem[7];
    issue(1, 8'h1C, ~hold_d, 4'hF, 0);
    chk("t5_exec_pulse", 32'(rm_reg_write), 32'd1);
    rst_n = 1'b0;
    #1;
    ref_cnt = 0;
    chk("t5_rm_wr", 32'(rm_reg_write), 32'd0);
    chk("t5_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("t5_req_ready", 32'(req_ready), 32'd1);
    chk("t5_rdata", rsp_rdata, 32'h0);
    chk("t5_err", 32'(rsp_err), 32'd0);
    chk("t5_cnt", 32'(err_count), 32'd0);
    chk("t5_wr_idx", 32'(rm_write_reg), 32'd0);
    chk("t5_wr_data", rm_write_data, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("t5_mem_kept", mem[7], hold_d);
    issue(0, 8'h1C, 32'h0, 4'h0, 1);
    drain();

    for (int i = 0; i < 300; i++)
      issue(i[0], 8'hC0 + 8'(i % 16), 32'h0, 4'hF, 1);
    drain();
    chk("t6_saturate", 32'(err_count), 32'd255);

    chk("pulse_total", 32'(pulses), 32'(exp_pulses));
    for (int i = 0; i < 48; i++)
      chk("final_mem", mem[i], ref_mem[i]);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
